// File: rtl/pcileech_sysctl_pkg.sv
// Shared types and sizing helpers for the pcileech system-control block.
package pcileech_sysctl_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_ACT   = 2'b11
    } led_mode_t;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } sysctl_state_t;

    localparam int HOLD_CNT_W = 16;

    // Width needed to hold the activity reload value itself.
    function automatic int stretch_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pcileech_sysctl_led.sv
// One LED channel: mode decode, activity pulse stretcher, polarity invert and output register.
module pcileech_sysctl_led
    import pcileech_sysctl_pkg::*;
#(
    parameter int PARAM_STRETCH_CYCLES = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic [1:0] mode,
    input  logic       act,
    input  logic       invert,
    input  logic       blink,
    output logic       led_out
);

    localparam int CNT_W = stretch_w(PARAM_STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PARAM_STRETCH_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             v;
    led_mode_t        m;

    // The stretcher runs regardless of mode; v looks at the post-edge count so
    // a strobe lights the LED one cycle later.
    always_comb begin
        m       = led_mode_t'(mode);
        cnt_nxt = cnt;
        if (act) begin
            cnt_nxt = CNT_LOAD;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end
        v = 1'b0;
        case (m)
            LED_OFF:   v = 1'b0;
            LED_ON:    v = 1'b1;
            LED_BLINK: v = blink;
            LED_ACT:   v = (cnt_nxt != '0);
            default:   v = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            led_out <= invert;
        end else begin
            cnt     <= cnt_nxt;
            led_out <= hold ? invert : (v ^ invert);
        end
    end

endmodule

// File: rtl/pcileech_sysctl.sv
// System control: 64-bit tickcount, stretched reset FSM and LED channels.
// Define PCILEECH_SYSCTL_PERST_RST_EN to make synchronised PERST# low an extra reset cause.
module pcileech_sysctl
    import pcileech_sysctl_pkg::*;
#(
    parameter int PARAM_RST_CYCLES     = 64,
    parameter int PARAM_LED_CNT        = 2,
    parameter int PARAM_BLINK_BIT      = 24,
    parameter int PARAM_STRETCH_CYCLES = 4194304
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pcie_perst_n,
    output logic [63:0]                tickcount64,
    output logic                       rst_out,
    input  logic [2*PARAM_LED_CNT-1:0] led_mode,
    input  logic [PARAM_LED_CNT-1:0]   led_act,
    input  logic [PARAM_LED_CNT-1:0]   led_invert,
    output logic [PARAM_LED_CNT-1:0]   led_out,
    output logic [1:0]                 dbg
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(PARAM_RST_CYCLES - 1);

    logic                  perst_meta;
    logic                  perst_sync;
    logic                  cause;
    logic [63:0]           tick_nxt;
    sysctl_state_t         state;
    sysctl_state_t         state_nxt;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [HOLD_CNT_W-1:0] hold_cnt_nxt;
    logic                  hold_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perst_meta <= 1'b1;
            perst_sync <= 1'b1;
        end else begin
            perst_meta <= pcie_perst_n;
            perst_sync <= perst_meta;
        end
    end

`ifdef PCILEECH_SYSCTL_PERST_RST_EN
    assign cause = ~perst_sync;
`else
    assign cause = 1'b0;
`endif

    assign tick_nxt = rst ? 64'd0 : tickcount64 + 64'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            tickcount64 <= '0;
        end else begin
            tickcount64 <= tick_nxt;
        end
    end

    // A cause arriving mid-hold pins the counter at 0, so the hold always
    // completes a full PARAM_RST_CYCLES after the last cause cycle.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (rst || cause) begin
            state_nxt    = S_HOLD;
            hold_cnt_nxt = '0;
        end else if (state == S_HOLD) begin
            if (hold_cnt == HOLD_LAST) begin
                state_nxt    = S_RUN;
                hold_cnt_nxt = '0;
            end else begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    assign rst_out  = (state == S_HOLD);
    assign hold_nxt = (state_nxt == S_HOLD);
    assign dbg      = {perst_sync, state};

    // Channels register from the next-state values so led_out is forced in
    // exactly the same cycles as rst_out and blink stays in phase with tickcount64.
    for (genvar i = 0; i < PARAM_LED_CNT; i++) begin : g_led
        pcileech_sysctl_led #(
            .PARAM_STRETCH_CYCLES(PARAM_STRETCH_CYCLES)
        ) u_led (
            .clk     (clk),
            .rst     (rst),
            .hold    (hold_nxt),
            .mode    (led_mode[2*i +: 2]),
            .act     (led_act[i]),
            .invert  (led_invert[i]),
            .blink   (tick_nxt[PARAM_BLINK_BIT]),
            .led_out (led_out[i])
        );
    end

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Scoreboard bench for pcileech_sysctl against a cycle-count based reference model.
module tb_pcileech_sysctl;

    localparam int RST_CYCLES = 64;
    localparam int LED_CNT    = 2;
    localparam int BLINK_BIT  = 3;
    localparam int STRETCH    = 16;
    localparam int W          = 64 + 1 + LED_CNT;
    localparam int BIG        = 1000000;
`ifdef PCILEECH_SYSCTL_PERST_RST_EN
    localparam bit PERST_EN = 1'b1;
`else
    localparam bit PERST_EN = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   pcie_perst_n;
    logic [63:0]            tickcount64;
    logic                   rst_out;
    logic [2*LED_CNT-1:0]   led_mode;
    logic [LED_CNT-1:0]     led_act;
    logic [LED_CNT-1:0]     led_invert;
    logic [LED_CNT-1:0]     led_out;
    logic [1:0]             dbg;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           fails  = 0;

    // Reference model: counts cycles since events instead of tracking hardware counters.
    logic [63:0] m_tick = '0;
    int          m_since = BIG;
    int          m_age[LED_CNT];
    logic [1:0]  m_perst = 2'b11;

    pcileech_sysctl #(
        .PARAM_RST_CYCLES    (RST_CYCLES),
        .PARAM_LED_CNT       (LED_CNT),
        .PARAM_BLINK_BIT     (BLINK_BIT),
        .PARAM_STRETCH_CYCLES(STRETCH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcie_perst_n (pcie_perst_n),
        .tickcount64  (tickcount64),
        .rst_out      (rst_out),
        .led_mode     (led_mode),
        .led_act      (led_act),
        .led_invert   (led_invert),
        .led_out      (led_out),
        .dbg          (dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_edge();
        logic [LED_CNT-1:0] led;
        logic               v;
        logic               rst_now;
        if (rst) begin
            m_tick  = '0;
            m_since = 0;
            m_perst = 2'b11;
            for (int i = 0; i < LED_CNT; i++) m_age[i] = BIG;
        end else begin
            m_tick = m_tick + 64'd1;
            if (PERST_EN && !m_perst[1]) m_since = 0;
            else if (m_since < BIG) m_since++;
            m_perst = {m_perst[0], pcie_perst_n};
            for (int i = 0; i < LED_CNT; i++) begin
                if (led_act[i]) m_age[i] = 0;
                else if (m_age[i] < BIG) m_age[i]++;
            end
        end
        rst_now = (m_since < RST_CYCLES);
        for (int i = 0; i < LED_CNT; i++) begin
            case (led_mode[2*i +: 2])
                2'b00:   v = 1'b0;
                2'b01:   v = 1'b1;
                2'b10:   v = m_tick[BLINK_BIT];
                default: v = (m_age[i] < STRETCH);
            endcase
            led[i] = rst_now ? led_invert[i] : (v ^ led_invert[i]);
        end
        exp_q.push_back({m_tick, rst_now, led});
    endtask

    task automatic step(input logic r, input logic p, input logic [3:0] m,
                        input logic [1:0] a, input logic [1:0] inv);
        rst          = r;
        pcie_perst_n = p;
        led_mode     = m;
        led_act      = a;
        led_invert   = inv;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Monitor: every cycle is an output beat; compare just after the edge.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL no_expected: DUT output with empty queue at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (tickcount64 !== e[W-1 -: 64]) begin
                    fails++;
                    $display("FAIL tickcount64: got %0h expected %0h at %0t", tickcount64, e[W-1 -: 64], $time);
                end
                checks++;
                if (rst_out !== e[LED_CNT]) begin
                    fails++;
                    $display("FAIL rst_out: got %b expected %b at %0t", rst_out, e[LED_CNT], $time);
                end
                checks++;
                if (led_out !== e[LED_CNT-1:0]) begin
                    fails++;
                    $display("FAIL led_out: got %b expected %b at %0t", led_out, e[LED_CNT-1:0], $time);
                end
            end
        end
    end

    initial begin
        logic [3:0] mode;
        logic [1:0] inv;
        logic [1:0] act;
        logic       r;
        logic       p;
        int         burst;
        for (int i = 0; i < LED_CNT; i++) m_age[i] = BIG;

        // Channel 0 activity, channel 1 blink.
        repeat (3) step(1'b1, 1'b1, 4'b1011, 2'b00, 2'b00);
        repeat (70) step(1'b0, 1'b1, 4'b1011, 2'b00, 2'b00);
        step(1'b0, 1'b1, 4'b1011, 2'b01, 2'b00);
        repeat (9) step(1'b0, 1'b1, 4'b1011, 2'b00, 2'b00);
        step(1'b0, 1'b1, 4'b1011, 2'b01, 2'b00);
        repeat (30) step(1'b0, 1'b1, 4'b1011, 2'b00, 2'b00);
        repeat (20) step(1'b0, 1'b1, 4'b1011, 2'b00, 2'b11);
        repeat (5) step(1'b0, 1'b1, 4'b0100, 2'b00, 2'b01);

        // Reset retriggered 40 cycles into the hold.
        step(1'b1, 1'b1, 4'b0110, 2'b00, 2'b00);
        repeat (39) step(1'b0, 1'b1, 4'b0110, 2'b00, 2'b00);
        step(1'b1, 1'b1, 4'b0110, 2'b00, 2'b00);
        repeat (80) step(1'b0, 1'b1, 4'b0110, 2'b00, 2'b00);

        // PERST# low for 10 cycles while running.
        repeat (10) step(1'b0, 1'b0, 4'b1101, 2'b00, 2'b10);
        repeat (80) step(1'b0, 1'b1, 4'b1101, 2'b00, 2'b10);

        mode  = 4'b1110;
        inv   = 2'b00;
        burst = 0;
        repeat (4000) begin
            r = ($urandom_range(0, 399) == 0);
            if (burst > 0) begin
                p = 1'b0;
                burst--;
            end else begin
                p = 1'b1;
                if ($urandom_range(0, 299) == 0) burst = $urandom_range(1, 20);
            end
            for (int i = 0; i < LED_CNT; i++) begin
                act[i] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 49) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) == 0) inv[i] = ~inv[i];
            end
            step(r, p, mode, act, inv);
        end

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
